// File: rtl/dls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dls_pkg
//  Description : Shared types, constants and helpers for the sequential
//                dynamic left shifter (dls_seq).
//  Options     : DLS_OVF_EN enables overflow tracking (uses step_mask).
//  Revision    : 1.0  initial release
// ============================================================================
package dls_pkg;

    // Shifter control states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } dls_state_t;

    // Widest word the discarded-bit mask helper can describe.
    localparam int c_mask_max = 256;

    // Default shift-amount width and the matching step-counter width.
    // The counter must be able to hold RS itself, hence the extra bit.
    localparam int c_rs_default = 5;
    localparam int c_cnt_w      = $clog2(c_rs_default) + 1;

    // Step-counter width for an arbitrary shift-amount width.
    function automatic int cnt_width(input int rs);
        return $clog2(rs) + 1;
    endfunction

    // Mask of the word bits pushed out of the MSB by a shift of 2**i.
    // Once 2**i reaches the word size every bit is lost.
    function automatic logic [c_mask_max-1:0] step_mask(input int i, input int word_size);
        logic [c_mask_max-1:0] m;
        int                    lim;
        m   = '0;
        lim = $clog2(word_size);
        for (int j = 0; j < c_mask_max; j++) begin
            if (j < word_size) begin
                if (i >= lim) begin
                    m[j] = 1'b1;
                end else if (j >= word_size - (1 << i)) begin
                    m[j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dls_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dls_seq_if
//  Description : Input/output valid-ready bus of the sequential dynamic left
//                shifter. master = producer/consumer side, slave = shifter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dls_seq_if #(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] a;
    logic [RS-1:0]        b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] c;
    logic                 ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dls_step.sv
`default_nettype none
// ============================================================================
//  Module      : dls_step
//  Description : Combinational conditional left shift by 2**i_idx, zero fill.
//                Shifts of 2**i_idx >= WORD_SIZE clear the word.
//  Options     : DLS_OVF_EN adds o_disc, the OR of the bits shifted out.
//  Revision    : 1.0  initial release
// ============================================================================
module dls_step
    import dls_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = 4
) (
    input  wire logic [CNT_W-1:0]     i_idx,
    input  wire logic                 i_en,
    input  wire logic [WORD_SIZE-1:0] i_word,
    output logic      [WORD_SIZE-1:0] o_word
`ifdef DLS_OVF_EN
    ,
    output logic                      o_disc
`endif
);

    // Smallest step index whose shift distance covers the whole word.
    localparam int c_lim = $clog2(WORD_SIZE);

    logic        w_big;
    logic [31:0] w_amt;

    // Apply the 2**i shift when enabled; oversize shifts flush to zero.
    always_comb begin
        w_big = (32'(i_idx) >= 32'(c_lim));
        w_amt = w_big ? 32'd0 : (32'd1 << i_idx);
        if (!i_en) begin
            o_word = i_word;
        end else if (w_big) begin
            o_word = '0;
        end else begin
            o_word = i_word << w_amt;
        end
    end

`ifdef DLS_OVF_EN
    logic [WORD_SIZE-1:0] w_mask;

    // Flag any 1-bit that this step pushes past the MSB.
    always_comb begin
        w_mask = WORD_SIZE'(step_mask(int'(i_idx), WORD_SIZE));
        o_disc = i_en && (|(i_word & w_mask));
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dls_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dls_seq
//  Description : Sequential dynamic left shifter. Consumes one shift-amount
//                bit per clock (fixed RS-cycle latency), valid/ready on both
//                sides, IDLE bubble between results.
//  Options     : DLS_OVF_EN - track 1-bits lost off the MSB on ovf;
//                otherwise ovf is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module dls_seq
    import dls_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5
) (
    input wire logic  clk,
    input wire logic  rst,
    dls_seq_if.slave  bus
);

    localparam int                 c_cnt_w = cnt_width(RS);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(RS - 1);

    dls_state_t           r_state;
    dls_state_t           w_next;
    logic [WORD_SIZE-1:0] r_work;
    logic [WORD_SIZE-1:0] w_step_word;
    logic [RS-1:0]        r_amt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_accept;
    logic                 w_last;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == c_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, one step per bit, hold result until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = SHIFT;
            SHIFT:   if (w_last)       w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; never ready while holding a result.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Working word, remaining amount bits (LSB = current step) and step count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_amt  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= bus.a;
            r_amt  <= bus.b;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_work <= w_step_word;
            r_amt  <= r_amt >> 1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign bus.c = r_work;

`ifdef DLS_OVF_EN
    logic w_disc;
    logic r_ovf;

    dls_step #(
        .WORD_SIZE (WORD_SIZE),
        .CNT_W     (c_cnt_w)
    ) u_step (
        .i_idx  (r_cnt),
        .i_en   (r_amt[0]),
        .i_word (r_work),
        .o_word (w_step_word),
        .o_disc (w_disc)
    );

    // Sticky overflow: cleared on accept, accumulates lost bits each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_ovf <= r_ovf | w_disc;
        end
    end

    assign bus.ovf = r_ovf;
`else
    dls_step #(
        .WORD_SIZE (WORD_SIZE),
        .CNT_W     (c_cnt_w)
    ) u_step (
        .i_idx  (r_cnt),
        .i_en   (r_amt[0]),
        .i_word (r_work),
        .o_word (w_step_word)
    );

    assign bus.ovf = 1'b0;
`endif

endmodule
`default_nettype wire
